fp16_add: RTL and testbench

Registered IEEE-754 binary16 adder: sums two half-precision operands with round-to-nearest-even and returns the result one clock after the operands are accepted. It is the accumulate stage of the FP16 MAC datapath. It sits downstream of the multiplier and feeds the systolic row accumulator.

---
 rtl/fp16_add_pkg.sv | 35 +++
 rtl/fp16_lzc.sv | 12 +
 rtl/fp16_add.sv | 118 +++++++++++
 tb/tb_fp16_add.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fp16_add_pkg.sv
// Shared FP16 definitions: field widths, bias, special encodings and operand unpacking.
package fp16_defs;

    localparam int FP16_WIDTH = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;

    localparam logic [FP16_WIDTH-1:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [FP16_WIDTH-1:0] FP16_NEG_ZERO = 16'h8000;
    localparam logic [FP16_WIDTH-1:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [FP16_WIDTH-1:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [FP16_WIDTH-1:0] FP16_QNAN     = 16'h7E00;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W:0]   sig;
    } fp16_unp_t;

    // Subnormals (and flushed subnormals) take exponent 1 so alignment treats them uniformly.
    function automatic fp16_unp_t fp16_unpack(input logic [FP16_WIDTH-1:0] v, input logic ftz);
        fp16_unp_t u;
        u.sign = v[15];
        if (v[14:10] == '0) begin
            u.exp = 5'd1;
            u.sig = ftz ? '0 : {1'b0, v[9:0]};
        end else begin
            u.exp = v[14:10];
            u.sig = {1'b1, v[9:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Combinational leading-zero counter over the 14-bit normalization significand (14 = all zero).
module fp16_lzc (
    input  logic [13:0] v,
    output logic [3:0]  cnt
);
    always_comb begin
        cnt = 4'd14;
        for (int unsigned i = 0; i < 14; i++) begin
            if (v[i]) cnt = 4'(13 - i);
        end
    end
endmodule

// File: rtl/fp16_add.sv
// Registered binary16 adder, round-to-nearest-even, one cycle latency.
// Define FP16_ADD_DENORM_EN for full subnormal support; otherwise flush-to-zero.
module fp16_add
    import fp16_defs::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [FP16_WIDTH-1:0] a,
    input  logic [FP16_WIDTH-1:0] b,
    output logic                  out_valid,
    output logic [FP16_WIDTH-1:0] y
);
`ifdef FP16_ADD_DENORM_EN
    localparam logic FTZ = 1'b0;
`else
    localparam logic FTZ = 1'b1;
`endif

    fp16_unp_t       ua, ub, ul, us;
    logic            a_nan, b_nan, a_inf, b_inf;
    logic [4:0]      d, sh;
    logic [24:0]     wide;
    logic [12:0]     al;
    logic            st;
    logic [13:0]     opl, ops;
    logic [14:0]     s;
    logic [3:0]      lz;
    logic [13:0]     n;
    logic [6:0]      e;
    logic            up;
    logic [11:0]     r;
    logic [10:0]     mant;
    logic [FP16_WIDTH-1:0] res;

    fp16_lzc u_lzc (.v(s[13:0]), .cnt(lz));

    always_comb begin
        ua    = fp16_unpack(a, FTZ);
        ub    = fp16_unpack(b, FTZ);
        a_nan = (&a[14:10]) & (|a[9:0]);
        b_nan = (&b[14:10]) & (|b[9:0]);
        a_inf = (&a[14:10]) & ~(|a[9:0]);
        b_inf = (&b[14:10]) & ~(|b[9:0]);

        if ({ub.exp, ub.sig} > {ua.exp, ua.sig}) begin
            ul = ub;
            us = ua;
        end else begin
            ul = ua;
            us = ub;
        end

        // Shifts below 14 lose nothing off the 25-bit window, so sticky is exact.
        d    = ul.exp - us.exp;
        wide = '0;
        if (d >= 5'd14) begin
            al = '0;
            st = |us.sig;
        end else begin
            wide = {us.sig, 14'b0} >> d;
            al   = wide[24:12];
            st   = |wide[11:0];
        end
        opl = {ul.sig, 3'b000};
        ops = {al, st};
        s   = (ua.sign ^ ub.sign) ? ({1'b0, opl} - {1'b0, ops}) : ({1'b0, opl} + {1'b0, ops});

        sh = '0;
        if (s[14]) begin
            n = {s[14:2], s[1] | s[0]};
            e = {2'b00, ul.exp} + 7'd1;
        end else begin
            sh = ({1'b0, lz} > (ul.exp - 5'd1)) ? (ul.exp - 5'd1) : {1'b0, lz};
            n  = s[13:0] << sh;
            e  = {2'b00, ul.exp} - {2'b00, sh};
        end

        up = n[2] & (n[1] | n[0] | n[3]);
        r  = {1'b0, n[13:3]} + {11'b0, up};
        if (r[11]) begin
            mant = r[11:1];
            e    = e + 7'd1;
        end else begin
            mant = r[10:0];
        end

        // Hidden bit clear means the result stayed at exponent 1 and encodes as subnormal.
        if (s == '0)
            res = (ua.sign & ub.sign) ? FP16_NEG_ZERO : FP16_POS_ZERO;
        else if (mant[10] && e >= 7'd31)
            res = ul.sign ? FP16_NEG_INF : FP16_POS_INF;
        else if (!mant[10])
            res = FTZ ? {ul.sign, 15'b0} : {ul.sign, 5'b0, mant[9:0]};
        else
            res = {ul.sign, e[4:0], mant[9:0]};

        if (a_nan || b_nan)
            res = FP16_QNAN;
        else if (a_inf && b_inf && (a[15] != b[15]))
            res = FP16_QNAN;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= FP16_POS_ZERO;
        end else begin
            out_valid <= in_valid;
            if (in_valid) y <= res;
        end
    end

endmodule

// File: tb/tb_fp16_add.sv
// Table-driven bench for fp16_add plus hand-written control sequences.
module tb_fp16_add;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic [15:0] y;

    int unsigned total  = 0;
    int unsigned passed = 0;
    vec_t        vecs[$];

    fp16_add dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .out_valid(out_valid), .y(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic issue(input logic [15:0] xa, input logic [15:0] xb);
        @(negedge clk);
        a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{16'h3C00, 16'h4000, 16'h4200});
        vecs.push_back('{16'h3E00, 16'h3E00, 16'h4200});
        vecs.push_back('{16'h4200, 16'h3A00, 16'h4380});
        vecs.push_back('{16'h3A00, 16'h4200, 16'h4380});
        vecs.push_back('{16'h4000, 16'hC200, 16'hBC00});
        vecs.push_back('{16'h3C00, 16'hBC00, 16'h0000});
        vecs.push_back('{16'h0000, 16'h4200, 16'h4200});
        vecs.push_back('{16'h8000, 16'h8000, 16'h8000});
        vecs.push_back('{16'h0000, 16'h8000, 16'h0000});
        vecs.push_back('{16'h7C00, 16'h3800, 16'h7C00});
        vecs.push_back('{16'hFC00, 16'h3800, 16'hFC00});
        vecs.push_back('{16'h7C00, 16'hFC00, 16'h7E00});
        vecs.push_back('{16'h7E01, 16'h3C00, 16'h7E00});
        vecs.push_back('{16'h7BFF, 16'h7BFF, 16'h7C00});
        vecs.push_back('{16'h3C00, 16'h1000, 16'h3C00});
        vecs.push_back('{16'h3C01, 16'h1000, 16'h3C02});
`ifdef FP16_ADD_DENORM_EN
        vecs.push_back('{16'h0001, 16'h0001, 16'h0002});
        vecs.push_back('{16'h03FF, 16'h0001, 16'h0400});
`else
        vecs.push_back('{16'h0001, 16'h0001, 16'h0000});
        vecs.push_back('{16'h03FF, 16'h0001, 16'h0000});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_y", y, 16'h0000);
        check("reset_valid", {15'b0, out_valid}, 16'h0001 & 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_valid", i), {15'b0, out_valid}, 16'h0001);
            check($sformatf("vec%0d_y %h+%h", i, vecs[i].a, vecs[i].b), y, vecs[i].y);
        end

        // Back-to-back stream: one result per cycle
        for (int k = 0; k < 4; k++) begin
            issue(vecs[k].a, vecs[k].b);
            check($sformatf("b2b%0d_valid", k), {15'b0, out_valid}, 16'h0001);
            check($sformatf("b2b%0d_y", k), y, vecs[k].y);
        end

        // Idle cycle: valid drops, y holds the last result
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'h3C00; b = 16'h3C00;
        @(posedge clk);
        #1;
        check("idle_valid", {15'b0, out_valid}, 16'h0000);
        check("idle_hold_y", y, vecs[3].y);

        // Asynchronous reset mid-stream, between clock edges
        issue(16'h4200, 16'h3A00);
        check("pre_rst_y", y, 16'h4380);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_y", y, 16'h0000);
        check("async_rst_valid", {15'b0, out_valid}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h3C01, 16'h1000);
        check("post_rst_valid", {15'b0, out_valid}, 16'h0001);
        check("post_rst_y", y, 16'h3C02);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_idle_valid", {15'b0, out_valid}, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
